// File: rtl/nn_pkg.sv
// Shared definitions for the neuron-layer datapath blocks.
package nn_pkg;

   parameter int DATA_W = 16;

   typedef logic [DATA_W-1:0] word_t;

   typedef enum logic {
      SER_IDLE = 1'b0,
      SER_SEND = 1'b1
   } ser_state_t;

endpackage

// File: rtl/ser_bank.sv
// One frame of neuron outputs: parallel load of all words, indexed combinational read.
module ser_bank #(
   parameter int depth = 30,
   parameter int width = 16
) (
   input  logic                       clk,
   input  logic                       load,
   input  logic [depth*width-1:0]     wr_data,
   input  logic [$clog2(depth)-1:0]   rd_idx,
   output logic [width-1:0]           rd_data
);

   logic [width-1:0] mem_reg [0:depth-1];

   always_ff @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < depth; i++) begin
            mem_reg[i] <= wr_data[i*width +: width];
         end
      end
   end

   assign rd_data = mem_reg[rd_idx];

endmodule

// File: rtl/layer_serializer.sv
// Captures a full layer of parallel neuron outputs into ping-pong banks and
// streams them one word per cycle to the next layer, neuron 0 first.
module layer_serializer
   import nn_pkg::*;
#(
   parameter int numNeurons = 30,
   parameter int dataWidth  = DATA_W
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [numNeurons*dataWidth-1:0] in_data,
   input  logic [numNeurons-1:0]           in_valid,
   output logic [dataWidth-1:0]            out_data,
   output logic                            out_valid,
   output logic                            out_last,
   output logic                            busy,
   output logic                            overflow,
   output logic                            skew_err
);

   localparam int            CW       = $clog2(numNeurons);
   localparam logic [CW-1:0] LAST_IDX = CW'(numNeurons - 1);

   ser_state_t           state_reg, state_next;
   logic [CW-1:0]        cnt_reg, cnt_next;
   logic                 rd_bank_reg, rd_bank_next;
   logic                 wr_bank_reg, wr_bank_next;
   logic [1:0]           full_reg, full_next;
   logic [dataWidth-1:0] out_data_reg, out_data_next;
   logic                 out_valid_reg, out_valid_next;
   logic                 out_last_reg, out_last_next;
   logic                 overflow_reg, overflow_next;
   logic                 skew_reg, skew_next;

   logic                 cap_all;
   logic                 last_word;
   logic                 wr_free;
   logic                 cap_ok;
   logic                 rd_sel;
   logic [CW-1:0]        rd_idx;
   logic [dataWidth-1:0] bank_rd [0:1];
   logic [dataWidth-1:0] sel_word;

   assign cap_all   = &in_valid;
   assign last_word = (state_reg == SER_SEND) && (cnt_reg == LAST_IDX);
   // The bank finishing its last word this cycle is free for a capture at the same edge.
   assign wr_free   = !full_reg[wr_bank_reg] || (last_word && (rd_bank_reg == wr_bank_reg));
   assign cap_ok    = cap_all && wr_free;

   for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      ser_bank #(
         .depth (numNeurons),
         .width (dataWidth)
      ) u_bank (
         .clk     (clk),
         .load    (cap_ok && (wr_bank_reg == 1'(gi))),
         .wr_data (in_data),
         .rd_idx  (rd_idx),
         .rd_data (bank_rd[gi])
      );
   end

   // Fetch the word that will be on the output after the next edge.
   always_comb begin
      rd_sel = rd_bank_reg;
      rd_idx = '0;
      if (last_word) begin
         rd_sel = ~rd_bank_reg;
      end else if (state_reg == SER_SEND) begin
         rd_idx = cnt_reg + CW'(1);
      end
   end

   assign sel_word = bank_rd[rd_sel];

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      rd_bank_next   = rd_bank_reg;
      wr_bank_next   = wr_bank_reg;
      full_next      = full_reg;
      out_data_next  = out_data_reg;
      out_valid_next = 1'b0;
      out_last_next  = 1'b0;
      overflow_next  = overflow_reg;
      skew_next      = skew_reg;

      unique case (state_reg)
         SER_IDLE: begin
            if (full_reg[rd_bank_reg]) begin
               state_next     = SER_SEND;
               cnt_next       = '0;
               out_valid_next = 1'b1;
               out_data_next  = sel_word;
            end
         end
         SER_SEND: begin
            if (last_word) begin
               full_next[rd_bank_reg] = 1'b0;
               rd_bank_next           = ~rd_bank_reg;
               cnt_next               = '0;
               if (full_reg[~rd_bank_reg]) begin
                  out_valid_next = 1'b1;
                  out_data_next  = sel_word;
               end else begin
                  state_next = SER_IDLE;
               end
            end else begin
               cnt_next       = cnt_reg + CW'(1);
               out_valid_next = 1'b1;
               out_data_next  = sel_word;
               out_last_next  = (cnt_reg + CW'(1)) == LAST_IDX;
            end
         end
         default: state_next = SER_IDLE;
      endcase

      if (cap_all) begin
         if (wr_free) begin
            full_next[wr_bank_reg] = 1'b1;
            wr_bank_next           = ~wr_bank_reg;
         end else begin
            overflow_next = 1'b1;
         end
      end else if (|in_valid) begin
         skew_next = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= SER_IDLE;
         cnt_reg       <= '0;
         rd_bank_reg   <= 1'b0;
         wr_bank_reg   <= 1'b0;
         full_reg      <= 2'b00;
         out_data_reg  <= '0;
         out_valid_reg <= 1'b0;
         out_last_reg  <= 1'b0;
         overflow_reg  <= 1'b0;
         skew_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         rd_bank_reg   <= rd_bank_next;
         wr_bank_reg   <= wr_bank_next;
         full_reg      <= full_next;
         out_data_reg  <= out_data_next;
         out_valid_reg <= out_valid_next;
         out_last_reg  <= out_last_next;
         overflow_reg  <= overflow_next;
         skew_reg      <= skew_next;
      end
   end

   assign out_data  = out_data_reg;
   assign out_valid = out_valid_reg;
   assign out_last  = out_last_reg;
   assign busy      = (|full_reg) || (state_reg == SER_SEND);
   assign overflow  = overflow_reg;
   assign skew_err  = skew_reg;

endmodule

// File: tb/tb_layer_serializer.sv
// Self-checking bench for layer_serializer: vector table, directed corner cases
// and a randomized run against a frame-queue reference model.
module tb_layer_serializer;

   localparam int N = 4;
   localparam int W = 16;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N*W-1:0] in_data = '0;
   logic [N-1:0]   in_valid = '0;
   logic [W-1:0]   out_data;
   logic           out_valid;
   logic           out_last;
   logic           busy;
   logic           overflow;
   logic           skew_err;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   layer_serializer #(
      .numNeurons (N),
      .dataWidth  (W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_last  (out_last),
      .busy      (busy),
      .overflow  (overflow),
      .skew_err  (skew_err)
   );

   // Reference model: queue of accepted frames (head is the one being streamed).
   logic [N*W-1:0] mq[$];
   int             m_pos = 0;
   bit             m_showing = 0;
   logic           m_valid = 0, m_last = 0, m_ovf = 0, m_skew = 0;
   logic [W-1:0]   m_data = '0;

   task automatic model_edge(input logic r, input logic [N-1:0] v, input logic [N*W-1:0] d);
      logic [N*W-1:0] head;
      if (r) begin
         mq.delete();
         m_showing = 0; m_pos = 0;
         m_valid = 0; m_last = 0; m_data = '0; m_ovf = 0; m_skew = 0;
         return;
      end
      if (m_showing && m_pos < N-1) begin
         m_pos++;
      end else begin
         if (m_showing) void'(mq.pop_front());
         m_showing = (mq.size() > 0);
         m_pos = 0;
      end
      m_valid = m_showing;
      m_last  = 1'b0;
      if (m_showing) begin
         head   = mq[0];
         m_data = head[m_pos*W +: W];
         m_last = (m_pos == N-1);
      end
      if (&v) begin
         if (mq.size() < 2) mq.push_back(d);
         else m_ovf = 1'b1;
      end else if (|v) begin
         m_skew = 1'b1;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic r, input logic [N-1:0] v, input logic [N*W-1:0] d);
      rst = r; in_valid = v; in_data = d;
      @(posedge clk);
      model_edge(r, v, d);
      #1;
      check("model_valid", out_valid, m_valid);
      check("model_data", out_data, m_data);
      check("model_last", out_last, m_last);
      check("model_busy", busy, (mq.size() > 0));
      check("model_ovf", overflow, m_ovf);
      check("model_skew", skew_err, m_skew);
   endtask

   function automatic logic [N*W-1:0] frame(input logic [W-1:0] base);
      logic [N*W-1:0] f;
      for (int k = 0; k < N; k++) f[k*W +: W] = base + W'(k);
      return f;
   endfunction

   typedef struct {
      logic           r;
      logic [N-1:0]   v;
      logic [N*W-1:0] d;
      logic           ev;
      logic [W-1:0]   ed;
      logic           el, eb, eo, es;
   } vec_t;

   vec_t           tbl [14];
   logic [13:1]    vh, lh;
   int             vcount;
   logic [W-1:0]   last_data;
   logic [N-1:0]   rv;
   int             sel;

   initial begin
      tbl[0]  = '{1'b1, 4'h0, 64'h0,                   1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 4'hF, 64'h0004_0003_0002_0001, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 4'h0, 64'h0,                   1'b1, 16'h1, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 4'h0, 64'h0,                   1'b1, 16'h2, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 4'h0, 64'h0,                   1'b1, 16'h3, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 4'h0, 64'h0,                   1'b1, 16'h4, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 4'h0, 64'h0,                   1'b0, 16'h4, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 4'h7, 64'h1111_1111_1111_1111, 1'b0, 16'h4, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[8]  = '{1'b0, 4'hF, 64'h0008_0007_0006_0005, 1'b0, 16'h4, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[9]  = '{1'b0, 4'h0, 64'h0,                   1'b1, 16'h5, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[10] = '{1'b0, 4'h0, 64'h0,                   1'b1, 16'h6, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[11] = '{1'b0, 4'h0, 64'h0,                   1'b1, 16'h7, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[12] = '{1'b0, 4'h0, 64'h0,                   1'b1, 16'h8, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[13] = '{1'b0, 4'h0, 64'h0,                   1'b0, 16'h8, 1'b0, 1'b0, 1'b0, 1'b1};

      // Single frame, then a skewed frame followed by a good one
      for (int i = 0; i < 14; i++) begin
         step(tbl[i].r, tbl[i].v, tbl[i].d);
         check($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
         check($sformatf("tbl%0d_data", i), out_data, tbl[i].ed);
         check($sformatf("tbl%0d_last", i), out_last, tbl[i].el);
         check($sformatf("tbl%0d_busy", i), busy, tbl[i].eb);
         check($sformatf("tbl%0d_ovf", i), overflow, tbl[i].eo);
         check($sformatf("tbl%0d_skew", i), skew_err, tbl[i].es);
         $display("[TB] vec %0d valid=%0b data=%0h last=%0b busy=%0b ovf=%0b skew=%0b",
                  i, out_valid, out_data, out_last, busy, overflow, skew_err);
      end

      // Second frame captured while word 2 of the first is on the output
      step(1'b1, '0, '0);
      step(1'b0, '1, frame(16'h10));
      vh = '0; lh = '0;
      for (int s = 1; s <= 9; s++) begin
         step(1'b0, (s == 2) ? 4'hF : 4'h0, frame(16'h20));
         vh[s] = out_valid; lh[s] = out_last;
      end
      check("t2_valid_mask", 32'(vh[9:1]), 32'h0FF);
      check("t2_last_mask", 32'(lh[9:1]), 32'h088);
      $display("[TB] back-to-back valid=%b last=%b", vh[9:1], lh[9:1]);

      // Three consecutive captures: third frame dropped
      step(1'b1, '0, '0);
      step(1'b0, '1, frame(16'h30));
      vcount = 0; last_data = '0;
      for (int s = 0; s < 14; s++) begin
         step(1'b0, (s < 2) ? 4'hF : 4'h0, (s == 0) ? frame(16'h40) : frame(16'h50));
         if (out_valid) begin vcount++; last_data = out_data; end
         if (s == 1) check("t3_ovf_set", overflow, 1'b1);
      end
      check("t3_word_count", vcount, 8);
      check("t3_last_word", last_data, 16'h43);
      check("t3_ovf_sticky", overflow, 1'b1);
      $display("[TB] overflow run words=%0d last=%0h ovf=%0b", vcount, last_data, overflow);

      // Capture on the same edge that frees bank 0 while bank 1 is full
      step(1'b1, '0, '0);
      step(1'b0, '1, frame(16'h60));
      vh = '0; last_data = '0;
      for (int s = 1; s <= 13; s++) begin
         step(1'b0, (s == 1 || s == 5) ? 4'hF : 4'h0, (s == 1) ? frame(16'h70) : frame(16'h80));
         vh[s] = out_valid;
         if (out_valid) last_data = out_data;
      end
      check("t4_valid_mask", 32'(vh[13:1]), 32'h0FFF);
      check("t4_no_ovf", overflow, 1'b0);
      check("t4_last_word", last_data, 16'h83);
      $display("[TB] freed-bank capture valid=%b ovf=%0b", vh[13:1], overflow);

      // Reset in the middle of a frame
      step(1'b1, '0, '0);
      step(1'b0, 4'h7, '0);
      step(1'b0, '1, frame(16'h90));
      step(1'b0, '0, '0);
      step(1'b0, '0, '0);
      check("t6_pre_word", out_data, 16'h91);
      step(1'b1, '0, '0);
      check("t6_rst_valid", out_valid, 1'b0);
      check("t6_rst_busy", busy, 1'b0);
      check("t6_rst_skew", skew_err, 1'b0);
      check("t6_rst_ovf", overflow, 1'b0);
      step(1'b0, '1, frame(16'hA0));
      step(1'b0, '0, '0);
      check("t6_restart_valid", out_valid, 1'b1);
      check("t6_restart_word0", out_data, 16'hA0);
      $display("[TB] mid-frame reset, restart word=%0h", out_data);

      // Randomized traffic against the reference model
      step(1'b1, '0, '0);
      for (int c = 0; c < 800; c++) begin
         sel = $urandom_range(0, 99);
         if (sel < 22) rv = '1;
         else if (sel < 24) rv = N'($urandom_range(1, (1 << N) - 2));
         else rv = '0;
         step(($urandom_range(0, 299) == 0), rv, {$urandom, $urandom});
         if (out_last) $display("[TB] cycle %0d frame end word=%0h", c, out_data);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
